// File: rtl/uart_dump_tx_if.sv
// Control and register-file bus of the score dump transmitter.
//   start   : one-cycle pulse requesting a dump (ignored while busy)
//   abort   : level, cancels a dump in progress
//   len     : number of note entries to send (addresses 0..len-1)
//   rd_data : register file read data, valid one clock after rd_addr
//   rd_addr : register file read address
//   busy    : dump in progress
//   done    : one-cycle pulse after the last stop bit
//   sent    : entries fully transmitted in the current or last dump
// master = controller plus register file side, slave = the transmitter.
interface uart_dump_tx_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 12
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] len;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sent;

    modport master (
        output start, abort, len, rd_data,
        input  rd_addr, busy, done, sent
    );

    modport slave (
        input  start, abort, len, rd_data,
        output rd_addr, busy, done, sent
    );
endinterface

// File: rtl/uart_dump_tx.sv
// UART transmitter that dumps the stored score from the note register file.
// On start it sends HEADER, then each 12-bit note as {4'b0, d[11:8]} and d[7:0]
// (8N1, LSB first, DIV = CLK_FREQ / BAUD clocks per bit), then pulses done.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : control / register file bus (slave side), see uart_dump_tx_if
//   tx    : serial output, idle high, registered
module uart_dump_tx #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 12,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_dump_tx_if.slave   bus,
    output logic            tx
);
    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    typedef enum logic [2:0] {
        StIdle, StHdr, StFetch, StWaitRd, StSendHi, StSendLo, StFinish
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  baud_q, baud_d;
    logic [3:0]        bit_q, bit_d;      // 0 = start, 1..8 = data, 9 = stop
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] sent_q, sent_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              tx_q, tx_d;

    logic sending, bit_end, frame_end;
    assign sending   = (state_q == StHdr) || (state_q == StSendHi) || (state_q == StSendLo);
    assign bit_end   = (baud_q == BAUD_LAST);
    assign frame_end = sending && bit_end && (bit_q == 4'd9);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            sent_q  <= '0;
            buf_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            sent_q  <= sent_d;
            buf_q   <= buf_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = '0;
        bit_d   = '0;
        len_d   = len_q;
        addr_d  = addr_q;
        sent_d  = sent_q;
        buf_d   = buf_q;

        // Bit timing runs only while a frame is on the line; the counters sit
        // at zero elsewhere so every frame starts with a full-length start bit.
        if (sending) begin
            if (bit_end) begin
                bit_d = frame_end ? 4'd0 : bit_q + 4'd1;
            end else begin
                baud_d = baud_q + CNT_W'(1);
                bit_d  = bit_q;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    len_d   = bus.len;
                    addr_d  = '0;
                    sent_d  = '0;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (frame_end) state_d = (len_q == '0) ? StFinish : StFetch;
            end
            StFetch:  state_d = StWaitRd;
            StWaitRd: begin
                buf_d   = bus.rd_data;
                state_d = StSendHi;
            end
            StSendHi: begin
                if (frame_end) state_d = StSendLo;
            end
            StSendLo: begin
                if (frame_end) begin
                    sent_d = sent_q + ADDR_W'(1);
                    if (sent_q + ADDR_W'(1) == len_q) begin
                        state_d = StFinish;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = StFetch;
                    end
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (bus.abort && (state_q != StIdle)) begin
            state_d = StIdle;
            baud_d  = '0;
            bit_d   = '0;
        end
    end

    // tx is registered from the next-state view so the line never glitches.
    logic [7:0] tx_byte;
    logic [2:0] data_idx;
    always_comb begin
        tx_byte  = 8'hFF;
        data_idx = 3'(bit_d - 4'd1);
        tx_d     = 1'b1;
        unique case (state_d)
            StHdr:    tx_byte = HEADER;
            StSendHi: tx_byte = {4'b0000, buf_d[11:8]};
            StSendLo: tx_byte = buf_d[7:0];
            default:  tx_byte = 8'hFF;
        endcase
        if ((state_d == StHdr) || (state_d == StSendHi) || (state_d == StSendLo)) begin
            if (bit_d == 4'd0) begin
                tx_d = 1'b0;
            end else if (bit_d <= 4'd8) begin
                tx_d = tx_byte[data_idx];
            end
        end
    end

    assign tx          = tx_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StFinish);
    assign bus.rd_addr = addr_q;
    assign bus.sent    = sent_q;
endmodule

// File: tb/tb_uart_dump_tx.sv
// Bench for uart_dump_tx: a line decoder turns tx back into bytes with their
// start times; each dump is compared with the byte stream and frame schedule
// computed from the register file contents.
module tb_uart_dump_tx;
    localparam int unsigned DIV = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic tx;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_dump_tx_if #(.ADDR_W(16), .DATA_W(12)) bus ();

    uart_dump_tx #(
        .CLK_FREQ(1000), .BAUD(100), .ADDR_W(16), .DATA_W(12), .HEADER(8'hA5)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .tx   (tx)
    );

    // Register file: one-clock read latency.
    logic [11:0] mem [16];
    always @(posedge clk) bus.rd_data <= mem[bus.rd_addr[3:0]];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line decoder: samples at negedge, checks every clock of every bit.
    logic [7:0] byte_q [$];
    int         t_q [$];
    int         a_q [$];
    int         frame_err = 0;
    logic [9:0] mon_bits;
    bit         mon_ok;
    int         mon_t0, mon_a;

    initial begin
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                mon_t0 = cyc;
                mon_a  = int'(bus.rd_addr);
                mon_ok = 1'b1;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < DIV; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (c == 0) mon_bits[b] = tx;
                        else if (tx !== mon_bits[b]) mon_ok = 1'b0;
                    end
                end
                if (mon_bits[9] !== 1'b1) mon_ok = 1'b0;
                if (!mon_ok) frame_err++;
                byte_q.push_back(mon_bits[8:1]);
                t_q.push_back(mon_t0);
                a_q.push_back(mon_a);
            end
        end
    end

    int done_cnt = 0;
    int done_cyc = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // One complete dump of n entries; restart_at != 0 pulses start again that
    // many clocks after the accepted start, with a different len.
    task automatic run_dump(input int n, input int restart_at, input string tag);
        logic [7:0] exp_b [$];
        int         exp_t [$];
        int         exp_a [$];
        int         sc, limit;
        bit         seen;
        exp_b.push_back(8'hA5); exp_t.push_back(0); exp_a.push_back(0);
        for (int i = 0; i < n; i++) begin
            exp_b.push_back({4'h0, mem[i][11:8]}); exp_t.push_back(102 + 202 * i); exp_a.push_back(i);
            exp_b.push_back(mem[i][7:0]);          exp_t.push_back(202 + 202 * i); exp_a.push_back(i);
        end
        byte_q.delete(); t_q.delete(); a_q.delete();
        frame_err = 0;
        done_cnt  = 0;
        @(posedge clk); #1;
        bus.len   = 16'(n);
        bus.start = 1'b1;
        sc        = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        limit = 100 + 202 * n + 20;
        seen  = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            if (restart_at != 0 && cyc == sc + restart_at) begin
                bus.start = 1'b1;
                bus.len   = 16'($urandom_range(5, 9));
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            seen = (done_cnt != 0);
        end
        bus.start = 1'b0;
        check({tag, ":done_seen"}, 32'(seen), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check({tag, ":done_count"}, done_cnt, 1);
        check({tag, ":done_cycle"}, done_cyc - (sc + 1), 100 + 202 * n);
        check({tag, ":idle_after"}, {tx, bus.busy, bus.done}, 3'b100);
        check({tag, ":sent"}, bus.sent, n);
        check({tag, ":rd_addr_end"}, bus.rd_addr, (n == 0) ? 0 : n - 1);
        check({tag, ":frame_errors"}, frame_err, 0);
        check({tag, ":byte_count"}, byte_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size() && i < byte_q.size(); i++) begin
            check($sformatf("%s:byte%0d", tag, i), byte_q[i], exp_b[i]);
            check($sformatf("%s:start_time%0d", tag, i), t_q[i] - (sc + 1), exp_t[i]);
            check($sformatf("%s:rd_addr%0d", tag, i), a_q[i], exp_a[i]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.len   = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", tx, 1);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_rd_addr", bus.rd_addr, 0);
        check("reset_sent", bus.sent, 0);
        rst_n = 1'b1;

        // Quiet idle.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_outputs", {tx, bus.busy, bus.done, bus.sent}, {1'b1, 1'b0, 1'b0, 16'h0});
        end
        check("idle_no_frames", byte_q.size(), 0);

        run_dump(0, 0, "len0");

        mem[0] = 12'h3C7;
        mem[1] = 12'h801;
        run_dump(2, 0, "len2");

        mem[2] = 12'($urandom);
        run_dump(3, 123, "restart_ignored");

        mem[0] = 12'h055;
        run_dump(1, 0, "bit55");

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) mem[i] = 12'($urandom);
            run_dump(int'($urandom_range(0, 6)), 0, $sformatf("rand%0d", r));
        end

        // Abort in the middle of the second entry's low byte (all-zero data
        // bits, so the line would be low without the abort).
        for (int i = 0; i < 4; i++) mem[i] = 12'($urandom);
        mem[1] = 12'h500;
        done_cnt = 0;
        @(posedge clk); #1;
        bus.len   = 16'd4;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (454) @(posedge clk);
        #1;
        check("abort_pre_busy", bus.busy, 1);
        check("abort_pre_tx", tx, 0);
        bus.abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_busy", bus.busy, 0);
        check("abort_sent", bus.sent, 1);
        check("abort_no_done", done_cnt, 0);
        // start together with abort while idle is refused.
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("abort_start_busy", bus.busy, 0);
        check("abort_start_sent", bus.sent, 1);
        @(posedge clk); #1;
        bus.abort = 1'b0;
        repeat (120) @(posedge clk);
        check("abort_still_no_done", done_cnt, 0);
        run_dump(4, 0, "after_abort");

        // Asynchronous reset during a low data bit of the header.
        @(posedge clk); #1;
        bus.len   = 16'd2;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (24) @(posedge clk);
        @(negedge clk);
        check("rst_pre_tx", tx, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", bus.busy, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (120) @(posedge clk);
        run_dump(2, 0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
